// File: rtl/avmm_wr_ack_expander.sv
// avmm_wr_ack_expander
//
// Expands per-burst write-ack events into per-beat AVMM write-ack pulses in
// the kernel clock domain. Each incoming ack carries the beat count of the
// burst it completes. The ack is queued in a small show-ahead FIFO. A
// two-state FSM then emits one out_wr_ack pulse per beat, with queued bursts
// following each other back-to-back.
//
// Optional feature: define AVMM_WR_ACK_EXPANDER_BYPASS_EN to let an ack load
// the beat counter directly when the FIFO is empty and the FSM is idle or on
// its last beat. This cuts the ack-to-pulse latency from 2 cycles to 1.
//
// Ports
//   kernel_avmm_clk      in   sole clock
//   kernel_avmm_reset_n  in   asynchronous active-low reset
//   in_wr_ack            in   one-cycle pulse, one burst completed
//   in_wr_ack_burstcnt   in   beat count of that burst (sampled with in_wr_ack)
//   out_wr_ack           out  per-beat write ack (registered)
//   almost_full          out  occupancy >= FIFO_DEPTH-ALMOST_FULL_THRESHOLD (registered)
//   err_overflow         out  sticky, ack dropped because the FIFO was full
//   err_zero_burst       out  sticky, ack with burstcnt=0 dropped
//
// state    | meaning
// ST_IDLE  | no beats pending, out_wr_ack low
// ST_BURST | emitting one beat per cycle, beats_left counts down to 1

module avmm_wr_ack_expander #(
   parameter int AVMM_BURSTCNT_WIDTH   = 7,
   parameter int FIFO_DEPTH            = 64,
   parameter int ALMOST_FULL_THRESHOLD = 4
) (
   input  logic                           kernel_avmm_clk,
   input  logic                           kernel_avmm_reset_n,
   input  logic                           in_wr_ack,
   input  logic [AVMM_BURSTCNT_WIDTH-1:0] in_wr_ack_burstcnt,
   output logic                           out_wr_ack,
   output logic                           almost_full,
   output logic                           err_overflow,
   output logic                           err_zero_burst
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = AVMM_BURSTCNT_WIDTH;

   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_AF   = (AW+1)'(FIFO_DEPTH - ALMOST_FULL_THRESHOLD);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [BW-1:0] BL_ONE   = BW'(1);
   localparam logic [BW-1:0] BL_ZERO  = '0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [BW-1:0]   beats_left, beats_nxt;

   logic [BW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count, count_nxt;
   logic            fifo_empty, fifo_full;
   logic [BW-1:0]   fifo_head;

   logic            ack_valid;
   logic            can_load;
   logic            last_beat;
   logic            pop;
   logic            push;
   logic            bypass;
   logic            drop_full;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_FULL);
   assign fifo_head  = mem[rd_ptr];

   assign ack_valid  = in_wr_ack && (in_wr_ack_burstcnt != BL_ZERO);
   assign last_beat  = (state == ST_BURST) && (beats_left == BL_ONE);
   assign can_load   = (state == ST_IDLE) || last_beat;

   always_comb begin
      state_nxt = state;
      beats_nxt = beats_left;
      pop       = 1'b0;
      bypass    = 1'b0;
      push      = 1'b0;
      drop_full = 1'b0;

`ifdef AVMM_WR_ACK_EXPANDER_BYPASS_EN
      bypass = ack_valid && fifo_empty && can_load;
`else
      bypass = 1'b0;
`endif

      pop = !fifo_empty && can_load;

      // A full FIFO still accepts if it is popped on the same edge.
      push      = ack_valid && !bypass && (!fifo_full || pop);
      drop_full = ack_valid && !bypass && fifo_full && !pop;

      if (pop) begin
         beats_nxt = fifo_head;
         state_nxt = ST_BURST;
      end else if (bypass) begin
         beats_nxt = in_wr_ack_burstcnt;
         state_nxt = ST_BURST;
      end else if (state == ST_BURST) begin
         beats_nxt = beats_left - BL_ONE;
         if (last_beat) begin
            state_nxt = ST_IDLE;
         end
      end

      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CNT_ONE;
      end else if (pop && !push) begin
         count_nxt = count - CNT_ONE;
      end
   end

   always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
      if (!kernel_avmm_reset_n) begin
         state      <= ST_IDLE;
         beats_left <= '0;
      end else begin
         state      <= state_nxt;
         beats_left <= beats_nxt;
      end
   end

   always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
      if (!kernel_avmm_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge kernel_avmm_clk) begin
      if (push) begin
         mem[wr_ptr] <= in_wr_ack_burstcnt;
      end
   end

   always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
      if (!kernel_avmm_reset_n) begin
         out_wr_ack     <= 1'b0;
         almost_full    <= 1'b0;
         err_overflow   <= 1'b0;
         err_zero_burst <= 1'b0;
      end else begin
         out_wr_ack     <= (state_nxt == ST_BURST);
         almost_full    <= (count_nxt >= CNT_AF);
         err_overflow   <= err_overflow | drop_full;
         err_zero_burst <= err_zero_burst | (in_wr_ack && (in_wr_ack_burstcnt == BL_ZERO));
      end
   end

endmodule

// File: tb/tb_avmm_wr_ack_expander.sv
// Directed testbench for avmm_wr_ack_expander in its default build
// (AVMM_WR_ACK_EXPANDER_BYPASS_EN undefined, FIFO_DEPTH=64).
module tb_avmm_wr_ack_expander;

   logic       clk;
   logic       rst_n;
   logic       in_wr_ack;
   logic [6:0] in_wr_ack_burstcnt;
   logic       out_wr_ack;
   logic       almost_full;
   logic       err_overflow;
   logic       err_zero_burst;

   int tests;
   int fails;
   int pulses;

   avmm_wr_ack_expander #(
      .AVMM_BURSTCNT_WIDTH   (7),
      .FIFO_DEPTH            (64),
      .ALMOST_FULL_THRESHOLD (4)
   ) dut (
      .kernel_avmm_clk     (clk),
      .kernel_avmm_reset_n (rst_n),
      .in_wr_ack           (in_wr_ack),
      .in_wr_ack_burstcnt  (in_wr_ack_burstcnt),
      .out_wr_ack          (out_wr_ack),
      .almost_full         (almost_full),
      .err_overflow        (err_overflow),
      .err_zero_burst      (err_zero_burst)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of input, then sample 1 time unit after the edge.
   task automatic step(input logic ack, input logic [6:0] cnt);
      in_wr_ack          = ack;
      in_wr_ack_burstcnt = cnt;
      @(posedge clk);
      #1;
      in_wr_ack          = 1'b0;
      in_wr_ack_burstcnt = '0;
      if (out_wr_ack === 1'b1) pulses++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 7'd0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pulses = 0;
   endtask

   logic [31:0] seq;

   initial begin
      tests              = 0;
      fails              = 0;
      pulses             = 0;
      rst_n              = 1'b0;
      in_wr_ack          = 1'b0;
      in_wr_ack_burstcnt = '0;

      // Reset state
      #11;
      chk_eq("rst_out",      {31'd0, out_wr_ack},     32'd0);
      chk_eq("rst_af",       {31'd0, almost_full},    32'd0);
      chk_eq("rst_ovf",      {31'd0, err_overflow},   32'd0);
      chk_eq("rst_zero",     {31'd0, err_zero_burst}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single ack of 1 beat: pulse appears 2 cycles after the ack cycle
      pulses = 0;
      step(1'b1, 7'd1);
      chk_eq("single_lat1",  {31'd0, out_wr_ack}, 32'd0);
      step(1'b0, 7'd0);
      chk_eq("single_lat2",  {31'd0, out_wr_ack}, 32'd1);
      step(1'b0, 7'd0);
      chk_eq("single_end",   {31'd0, out_wr_ack}, 32'd0);
      idle(5);
      chk_eq("single_total", pulses, 32'd1);
      chk_eq("single_ovf",   {31'd0, err_overflow},   32'd0);
      chk_eq("single_zero",  {31'd0, err_zero_burst}, 32'd0);

      // Bursts of 4 then 3 on consecutive cycles: 7 contiguous beats
      pulses = 0;
      step(1'b1, 7'd4);
      step(1'b1, 7'd3);
      chk_eq("b43_first",    {31'd0, out_wr_ack}, 32'd1);
      seq = '0;
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 7'd0);
         seq[i] = out_wr_ack;
      end
      chk_eq("b43_shape",    seq, 32'h0000_003F);
      chk_eq("b43_total",    pulses, 32'd7);
      idle(10);
      chk_eq("b43_drained",  pulses, 32'd7);

      // Second burst arrives while the first is still draining: no gap
      pulses = 0;
      step(1'b1, 7'd3);
      step(1'b0, 7'd0);
      step(1'b0, 7'd0);
      step(1'b1, 7'd2);
      seq = '0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 7'd0);
         seq[i] = out_wr_ack;
      end
      // samples after edges 4..9: beats continue through edge 5, low from 6
      chk_eq("gap_shape",    seq, 32'h0000_0003);
      chk_eq("gap_total",    pulses, 32'd5);

      // Zero burst count: dropped, sticky error
      pulses = 0;
      step(1'b1, 7'd0);
      chk_eq("zero_flag",    {31'd0, err_zero_burst}, 32'd1);
      idle(100);
      chk_eq("zero_sticky",  {31'd0, err_zero_burst}, 32'd1);
      chk_eq("zero_pulses",  pulses, 32'd0);
      pulse_reset();
      chk_eq("zero_cleared", {31'd0, err_zero_burst}, 32'd0);

      // Overflow: 127-beat burst then 65 single-beat acks back-to-back.
      // The 127 entry is popped on the next edge, so after ack k the
      // occupancy is k; ack 65 finds 64 entries and no pop, and is dropped.
      pulses = 0;
      step(1'b1, 7'd127);
      for (int k = 1; k <= 65; k++) begin
         step(1'b1, 7'd1);
         if (k == 59) chk_eq("af_at59",  {31'd0, almost_full},  32'd0);
         if (k == 60) chk_eq("af_at60",  {31'd0, almost_full},  32'd1);
         if (k == 64) chk_eq("ovf_at64", {31'd0, err_overflow}, 32'd0);
         if (k == 65) chk_eq("ovf_at65", {31'd0, err_overflow}, 32'd1);
      end
      idle(200);
      chk_eq("ovf_total",    pulses, 32'd191);
      chk_eq("ovf_sticky",   {31'd0, err_overflow}, 32'd1);
      chk_eq("ovf_af_clear", {31'd0, almost_full},  32'd0);
      chk_eq("ovf_idle",     {31'd0, out_wr_ack},   32'd0);
      pulse_reset();

      // Asynchronous reset mid-burst of 8 after 3 beats, 2 entries queued
      pulses = 0;
      step(1'b1, 7'd8);
      step(1'b1, 7'd2);
      step(1'b1, 7'd3);
      step(1'b1, 7'd0);
      chk_eq("mid_beats",    pulses, 32'd3);
      chk_eq("mid_active",   {31'd0, out_wr_ack},     32'd1);
      chk_eq("mid_zero_set", {31'd0, err_zero_burst}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_eq("arst_out",     {31'd0, out_wr_ack},     32'd0);
      chk_eq("arst_zero",    {31'd0, err_zero_burst}, 32'd0);
      chk_eq("arst_af",      {31'd0, almost_full},    32'd0);
      chk_eq("arst_ovf",     {31'd0, err_overflow},   32'd0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pulses = 0;
      idle(20);
      chk_eq("arst_no_replay", pulses, 32'd0);
      step(1'b1, 7'd2);
      idle(5);
      chk_eq("arst_recover", pulses, 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
